// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
// Shared types and helpers for the dot_product_stream block.
//   state_e     : top-level FSM states (ACC, DRAIN, OUT).
//   acc_width() : accumulator width that cannot overflow for n products of
//                 two w-bit signed operands.
//   sat_narrow(): clamps a wide signed sum into the signed w-bit range.
// Helpers operate on fixed maximum widths so that any W <= MAX_W can use them.
// The caller sign-extends into MAX_ACC_W bits and size-casts the result down.
// -----------------------------------------------------------------------------
package dot_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_ACC_W = 2 * MAX_W + 32;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  function automatic logic [MAX_W-1:0] sat_narrow(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          w
  );
    logic signed [MAX_ACC_W-1:0] max_pos;
    logic signed [MAX_ACC_W-1:0] min_neg;
    logic signed [MAX_ACC_W-1:0] clamped;
    max_pos = (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
    min_neg = ~max_pos;
    if (acc > max_pos) begin
      clamped = max_pos;
    end else if (acc < min_neg) begin
      clamped = min_neg;
    end else begin
      clamped = acc;
    end
    return clamped[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/dot_product_stream_mul_reg.sv
// -----------------------------------------------------------------------------
// mul_reg
// Stage-1 boundary of dot_product_stream: signed W x W multiply followed by an
// output register and a valid flag. Kept as its own module so that synthesis
// can map it onto a DSP block with its internal output register.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            capture a new product this cycle (an operand pair is popped)
//   a, b          W-bit two's-complement operands
//   prod          registered 2W-bit signed product
//   prod_v        prod holds a product that has not yet been accumulated
// -----------------------------------------------------------------------------
module mul_reg
  import dot_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           prod_v
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] prod_d, prod_q;
  logic                  prod_v_d, prod_v_q;

  // Operands are sign-extended to the full product width first; the low 2W
  // bits of a 2W x 2W multiply equal the exact W x W signed product.
  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    prod_d   = prod_q;
    prod_v_d = en;
    if (en) begin
      prod_d = a_ext * b_ext;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

  assign prod   = prod_q;
  assign prod_v = prod_v_q;

endmodule

// File: rtl/dot_product_stream.sv
// -----------------------------------------------------------------------------
// dot_product_stream
// Joins two operand streams (A and B fifo outputs), multiplies element pairs
// and accumulates N products into one signed dot product, which is presented
// on a valid/ready output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_data/a_valid/a_ready   A operand stream (a_ready = pop)
//   b_data/b_valid/b_ready   B operand stream (b_ready = pop)
//   m_data/m_valid/m_ready   result stream, m_data held until accepted
// Build option:
//   DOT_SAT_EN  defined   -> m_data is the sum saturated to the W-bit range
//               undefined -> m_data is the sum truncated to its low W bits
// Timing: last pop in cycle t -> m_valid in cycle t+2; N+2 cycles per result
// with continuous operands and no output stall.
// -----------------------------------------------------------------------------
module dot_product_stream
  import dot_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_data,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] b_data,
  input  logic         b_valid,
  output logic         b_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  localparam int ACC_W = acc_width(W, N);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_e                   state_d, state_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic [W-1:0]             m_data_d, m_data_q;
  logic                     m_valid_d, m_valid_q;

  logic                     pop;
  logic [2*W-1:0]           prod;
  logic                     prod_v;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic [W-1:0]             narrowed;

  // Join: a pair is popped only when both sides are valid. Ready is a function
  // of valid (never the reverse), so no combinational loop with a FWFT fifo.
  assign pop     = (state_q == ST_ACC) && a_valid && b_valid && !rst;
  assign a_ready = pop;
  assign b_ready = pop;

  mul_reg #(.W(W)) u_mul_reg (
    .clk    (clk),
    .rst    (rst),
    .en     (pop),
    .a      (a_data),
    .b      (b_data),
    .prod   (prod),
    .prod_v (prod_v)
  );

  assign prod_ext = {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
  assign sum_next = prod_v ? (acc_q + prod_ext) : acc_q;

`ifdef DOT_SAT_EN
  assign narrowed = W'(sat_narrow(MAX_ACC_W'(sum_next), W));
`else
  assign narrowed = sum_next[W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = sum_next;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    unique case (state_q)
      ST_ACC: begin
        if (pop) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The last product lands in acc at this edge; the result register
        // captures the same final sum so it is visible together with m_valid.
        state_d   = ST_OUT;
        m_valid_d = 1'b1;
        m_data_d  = narrowed;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          acc_d     = '0;
          state_d   = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// -----------------------------------------------------------------------------
// tb_dot_product_stream
// Self-checking bench for dot_product_stream (W=16, N=8). Operand fifos are
// modelled as queues; expected results are computed with integer arithmetic
// from each vector's elements. Compile with +define+DOT_SAT_EN to check the
// saturating build.
// -----------------------------------------------------------------------------
module tb_dot_product_stream;

  localparam int W = 16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  always #5 clk = ~clk;

  dot_product_stream #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] exp_q[$];

  int           cyc          = 0;
  int           pops         = 0;
  int           last_pop_cyc = -100;
  int           last_rise    = -1;
  bit           prev_mv      = 1'b0;
  bit           prev_mr      = 1'b0;
  logic [W-1:0] prev_md      = '0;

  // Stimulus modes: a_gap 0=always valid, 1=random bubbles
  //                 b_gap 0=always valid, 1=alternate 1010, 2=random bubbles
  //                 r_mode 0=always ready, 1=random, 2=stall stall_left cycles
  int a_gap      = 0;
  int b_gap      = 0;
  int r_mode     = 0;
  int stall_left = 0;
  bit tp_check   = 1'b0;

  // Reference: exact dot product in 64-bit integers, then the output rule.
  function automatic logic [W-1:0] model_result(input logic [W-1:0] av[N],
                                                input logic [W-1:0] bv[N]);
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      s += longint'($signed(av[i])) * longint'($signed(bv[i]));
    end
`ifdef DOT_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[W-1:0];
  endfunction

  task automatic load_vector(input logic [W-1:0] av[N], input logic [W-1:0] bv[N]);
    for (int i = 0; i < N; i++) begin
      qa.push_back(av[i]);
      qb.push_back(bv[i]);
    end
    exp_q.push_back(model_result(av, bv));
  endtask

  task automatic load_const(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] av[N];
    logic [W-1:0] bv[N];
    for (int i = 0; i < N; i++) begin
      av[i] = a;
      bv[i] = b;
    end
    load_vector(av, bv);
  endtask

  task automatic load_ramp();
    logic [W-1:0] av[N];
    logic [W-1:0] bv[N];
    for (int i = 0; i < N; i++) begin
      av[i] = W'(i + 1);
      bv[i] = W'(1);
    end
    load_vector(av, bv);
  endtask

  // One clock cycle: drive after the previous edge, observe at the falling
  // edge, then advance past the next rising edge and retire popped operands.
  task automatic cycle();
    bit pop;
    a_valid = (qa.size() > 0) && (a_gap == 0 || $urandom_range(0, 3) != 0);
    case (b_gap)
      1:       b_valid = (qb.size() > 0) && (cyc % 2 == 0);
      2:       b_valid = (qb.size() > 0) && ($urandom_range(0, 2) != 0);
      default: b_valid = (qb.size() > 0);
    endcase
    a_data = a_valid ? qa[0] : W'($urandom);
    b_data = b_valid ? qb[0] : W'($urandom);
    case (r_mode)
      1:       m_ready = ($urandom_range(0, 2) == 0);
      2:       m_ready = (stall_left == 0);
      default: m_ready = 1'b1;
    endcase

    @(negedge clk);
    checks++;
    if (a_ready !== b_ready) begin
      failures++;
      $display("FAIL ready_join cyc=%0d: a_ready=%b b_ready=%b, required equal", cyc, a_ready, b_ready);
    end
    checks++;
    if (a_ready === 1'b1 && !(a_valid && b_valid)) begin
      failures++;
      $display("FAIL ready_without_pair cyc=%0d: a_ready=1 with a_valid=%b b_valid=%b, required 0",
               cyc, a_valid, b_valid);
    end
    if (m_valid === 1'b1) begin
      checks++;
      if (a_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_while_output cyc=%0d: a_ready=%b while m_valid=1, required 0", cyc, a_ready);
      end
    end
    if (prev_mv && !prev_mr) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_md) begin
        failures++;
        $display("FAIL output_hold cyc=%0d: m_valid=%b m_data=%h, required 1 / %h",
                 cyc, m_valid, m_data, prev_md);
      end
    end
    if (m_valid === 1'b1 && !prev_mv) begin
      checks++;
      if (cyc - last_pop_cyc != 2) begin
        failures++;
        $display("FAIL latency cyc=%0d: m_valid rose %0d cycles after last pop, required 2",
                 cyc, cyc - last_pop_cyc);
      end
      if (tp_check && last_rise >= 0) begin
        checks++;
        if (cyc - last_rise != N + 2) begin
          failures++;
          $display("FAIL throughput cyc=%0d: %0d cycles between results, required %0d",
                   cyc, cyc - last_rise, N + 2);
        end
      end
      last_rise = cyc;
    end
    if (m_valid === 1'b1 && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result cyc=%0d: got %h, required no result", cyc, m_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          failures++;
          $display("FAIL result cyc=%0d: m_data=%h, required %h", cyc, m_data, e);
        end
      end
    end
    if (m_valid === 1'b1 && !m_ready && stall_left > 0) stall_left--;
    pop = (a_ready === 1'b1) && a_valid && b_valid;
    if (pop) begin
      pops++;
      if (pops == N) begin
        last_pop_cyc = cyc;
        pops = 0;
      end
    end
    prev_mv = (m_valid === 1'b1);
    prev_mr = m_ready;
    prev_md = m_data;

    @(posedge clk);
    #1;
    if (pop) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    cyc++;
  endtask

  task automatic run_until_done(input string name);
    int budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d results and %0d/%0d operands left, required 0",
               name, exp_q.size(), qa.size(), qb.size());
      exp_q.delete();
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic set_modes(input int ag, input int bg, input int rm, input bit tp);
    a_gap     = ag;
    b_gap     = bg;
    r_mode    = rm;
    tp_check  = tp;
    last_rise = -1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = W'(5);
    b_data  = W'(7);
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: m_valid=%b m_data=%h, required 0 / 0000", m_valid, m_data);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 0 / 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: a_ready=%b m_valid=%b, required 0 / 0", a_ready, m_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    set_modes(0, 0, 0, 1'b0);
    load_ramp();
    run_until_done("basic");
  endtask

  task automatic test_signed();
    set_modes(0, 0, 0, 1'b0);
    load_const(W'(-3), W'(5));
    run_until_done("signed");
  endtask

  task automatic test_backpressure();
    set_modes(0, 0, 2, 1'b0);
    stall_left = 5;
    load_ramp();
    load_const(W'(2), W'(2));
    run_until_done("backpressure");
  endtask

  task automatic test_skew();
    set_modes(0, 1, 0, 1'b0);
    load_ramp();
    run_until_done("skew");
  endtask

  task automatic test_overflow();
    set_modes(0, 0, 0, 1'b0);
    load_const(16'h7FFF, 16'h7FFF);
    load_const(16'h8000, 16'h7FFF);
    load_const(16'h8000, 16'h8000);
    run_until_done("overflow");
  endtask

  task automatic test_back_to_back();
    set_modes(0, 0, 0, 1'b1);
    load_ramp();
    load_const(W'(2), W'(2));
    load_const(W'(-1), W'(7));
    run_until_done("back_to_back");
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    set_modes(0, 0, 0, 1'b0);
    load_ramp();
    while (pops < 3 && guard < 50) begin
      cycle();
      guard++;
    end
    checks++;
    if (pops != 3) begin
      failures++;
      $display("FAIL reset_mid_pops: %0d pops seen, required 3", pops);
    end
    // Upstream fifos reset together with the block: drop pending operands.
    qa.delete();
    qb.delete();
    exp_q.delete();
    rst = 1'b1;
    cycle();
    rst  = 1'b0;
    pops = 0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: m_valid=%b a_ready=%b, required 0 / 0", m_valid, a_ready);
    end
    @(posedge clk);
    #1;
    cyc++;
    load_ramp();
    run_until_done("reset_mid");
  endtask

  task automatic test_random();
    logic [W-1:0] av[N];
    logic [W-1:0] bv[N];
    set_modes(1, 2, 1, 1'b0);
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < N; i++) begin
        if (v % 4 == 3) begin
          av[i] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
          bv[i] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        end else begin
          av[i] = W'($urandom);
          bv[i] = W'($urandom);
        end
      end
      load_vector(av, bv);
    end
    run_until_done("random");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_skew();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
